// File: rtl/mac_dot_ctrl.sv
// Dot-product MAC controller: accepts len operand pairs, multiplies each into a
// product stage and accumulates into a 64-bit result with a sticky carry flag.
module mac_dot_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [63:0]      result,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      acc_q;
  logic             ovf_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic [63:0]      prod_q;
  logic             pv_q;

  logic             clr;
  logic             accept;
  logic [64:0]      sum;

  assign in_ready = (state_q == S_RUN);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = acc_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    accept  = 1'b0;
    sum     = {1'b0, acc_q} + {1'b0, prod_q};
    if (abort) begin
      state_d = S_IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            clr     = 1'b1;
            state_d = (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          accept = in_valid;
          // len_q is nonzero in RUN, so len_q-1 never wraps
          if (in_valid && (cnt_q == len_q - LEN_W'(1)))
            state_d = S_DRAIN;
        end
        S_DRAIN: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      len_q  <= '0;
      prod_q <= '0;
      pv_q   <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      pv_q  <= 1'b0;
      if (!abort)
        len_q <= len;
    end else begin
      pv_q <= accept;
      if (accept) begin
        prod_q <= {32'b0, a} * {32'b0, b};
        cnt_q  <= cnt_q + LEN_W'(1);
      end
      if (pv_q) begin
        acc_q <= sum[63:0];
        if (sum[64])
          ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed bench for mac_dot_ctrl: fixed jobs with hand-computed results,
// covering gaps, carry-out, empty jobs, abort and asynchronous reset.
module tb_mac_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  mac_dot_ctrl #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] x, input logic [31:0] y);
    a = x; b = y; in_valid = 1'b1;
  endtask

  initial begin
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", in_ready, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // len=3 back-to-back: 6+20+42 = 68
    start = 1'b1; len = 16'd3;
    cyc();
    start = 1'b0;
    check_val("t1_busy", busy, 1);
    check_val("t1_ready", in_ready, 1);
    feed(2, 3); cyc();
    feed(4, 5); cyc();
    feed(6, 7); cyc();
    in_valid = 1'b0;
    check_val("t1_drain_ready", in_ready, 0);
    check_val("t1_drain_done", done, 0);
    cyc();
    check_val("t1_done", done, 1);
    check_val("t1_result", result, 64'd68);
    check_val("t1_ovf", overflow, 0);
    cyc();
    check_val("t1_idle_done", done, 0);
    check_val("t1_idle_busy", busy, 0);
    check_val("t1_hold", result, 64'd68);

    // len=2 with a 3-cycle in_valid gap: 100+1 = 101
    start = 1'b1; len = 16'd2;
    cyc();
    start = 1'b0;
    feed(10, 10); cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("t2_gap_ready", in_ready, 1);
      check_val("t2_gap_done", done, 0);
      cyc();
    end
    feed(1, 1); cyc();
    in_valid = 1'b0;
    check_val("t2_drain_done", done, 0);
    cyc();
    check_val("t2_done", done, 1);
    check_val("t2_result", result, 64'd101);
    cyc();

    // carry-out: 2 * FFFFFFFE00000001 mod 2^64
    start = 1'b1; len = 16'd2;
    cyc();
    start = 1'b0;
    feed(32'hFFFF_FFFF, 32'hFFFF_FFFF); cyc();
    feed(32'hFFFF_FFFF, 32'hFFFF_FFFF); cyc();
    in_valid = 1'b0;
    cyc();
    check_val("t3_done", done, 1);
    check_val("t3_result", result, 64'hFFFF_FFFC_0000_0002);
    check_val("t3_ovf", overflow, 1);
    cyc();
    check_val("t3_ovf_sticky", overflow, 1);

    // len=0: straight to DONE, result and overflow cleared
    start = 1'b1; len = 16'd0;
    cyc();
    start = 1'b0;
    check_val("t4_busy", busy, 1);
    check_val("t4_done", done, 1);
    check_val("t4_ready", in_ready, 0);
    check_val("t4_result", result, 0);
    check_val("t4_ovf", overflow, 0);
    cyc();
    check_val("t4_idle", busy, 0);
    check_val("t4_done_gone", done, 0);

    // abort after two accepts, with start and in_valid also high
    start = 1'b1; len = 16'd4;
    cyc();
    start = 1'b0;
    feed(1, 2); cyc();
    feed(3, 4); cyc();
    abort = 1'b1; start = 1'b1; feed(5, 5);
    cyc();
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    check_val("t5_abort_busy", busy, 0);
    check_val("t5_abort_result", result, 0);
    check_val("t5_abort_done", done, 0);
    check_val("t5_abort_ready", in_ready, 0);
    cyc();
    check_val("t5_no_done", done, 0);
    // abort beats start in IDLE
    abort = 1'b1; start = 1'b1; len = 16'd5;
    cyc();
    abort = 1'b0; start = 1'b0;
    check_val("t5_abort_start", busy, 0);
    start = 1'b1; len = 16'd1;
    cyc();
    start = 1'b0;
    feed(3, 3); cyc();
    in_valid = 1'b0;
    cyc();
    check_val("t5_done", done, 1);
    check_val("t5_result", result, 64'd9);
    cyc();

    // asynchronous reset between edges mid-RUN
    start = 1'b1; len = 16'd2;
    cyc();
    start = 1'b0;
    feed(5, 5); cyc();
    in_valid = 1'b0;
    cyc();
    check_val("t6_pre_result", result, 64'd25);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_ready", in_ready, 0);
    check_val("t6_rst_result", result, 0);
    check_val("t6_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check_val("t6_post_busy", busy, 0);
    check_val("t6_post_done", done, 0);

    // start during DONE is ignored
    start = 1'b1; len = 16'd1;
    cyc();
    start = 1'b0;
    feed(2, 2); cyc();
    in_valid = 1'b0;
    cyc();
    check_val("t7_done", done, 1);
    check_val("t7_result", result, 64'd4);
    start = 1'b1; len = 16'd1;
    cyc();
    start = 1'b0;
    check_val("t7_ignored_busy", busy, 0);
    check_val("t7_hold", result, 64'd4);
    cyc();
    check_val("t7_still_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_ctrl.md
MAC_DOT_CTRL -- requirements
Module: mac_dot_ctrl

Interface
REQ-001 Parameter LEN_W, default 16: width of job-length field and element counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  job request; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of operand pairs in job; captured when start accepted.
REQ-006 abort  input  1  synchronous job cancel.
REQ-007 a, b  input  32 each  unsigned operand pair.
REQ-008 in_valid  input  1  a/b valid this cycle.
REQ-009 in_ready  output  1  block accepts a/b this cycle.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse: job complete, result final.
REQ-012 result  output  64  accumulated sum of products.
REQ-013 overflow  output  1  sticky: accumulator carry-out during current/last job.

Function
REQ-014 States SHALL be IDLE, RUN, DRAIN, DONE; encoding free.
REQ-015 IDLE and start=1, len!=0: next state RUN; accumulator, overflow, counter, product-valid SHALL clear on that edge.
REQ-016 IDLE and start=1, len=0: next state DONE; accumulator and overflow clear; result=0 at done.
REQ-017 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-018 in_ready SHALL be 1 only in RUN, combinationally from state.
REQ-019 Pair accepted on edge where in_valid=1 and in_ready=1; in_valid without in_ready has no effect.
REQ-020 Accepted pair: 64-bit unsigned product a*b registered into product stage with product-valid=1 on that edge; product-valid=0 after any edge with no acceptance.
REQ-021 Each edge with product-valid=1: accumulator += product, modulo 2^64; carry-out sets overflow.
REQ-022 Element counter SHALL increment per accepted pair; acceptance of pair number len moves RUN to DRAIN.
REQ-023 DRAIN SHALL last exactly one cycle (final product added), then DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1, then IDLE.
REQ-025 Latency: done asserts in second cycle after last-accept cycle; in_valid gaps in RUN stall without loss.
REQ-026 result SHALL equal accumulator continuously; value at done SHALL be held until next accepted start.
REQ-027 overflow SHALL remain set until next accepted start or reset.
REQ-028 abort=1 in any state: next state IDLE, accumulator, overflow, counter, product-valid clear, no done pulse; abort has priority over start and acceptance in same cycle.
REQ-029 start and abort same IDLE cycle: abort wins, start discarded.
REQ-030 len=2^LEN_W-1 SHALL be supported without counter wrap.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, in_ready=0, busy=0, done=0, result=0, overflow=0, counter=0, product-valid=0, regardless of clk.
REQ-032 Reset asserted mid-job SHALL discard job with no done pulse; first edge after release sees IDLE.

Verification
REQ-033 len=3, pairs (2,3),(4,5),(6,7) back-to-back -> done two cycles after third accept, result=68, overflow=0.
REQ-034 len=2, pairs (10,10),(1,1) with 3 idle in_valid cycles between -> result=101, done two cycles after second accept, in_ready high throughout gap.
REQ-035 len=2, pairs (FFFFFFFF,FFFFFFFF) twice -> result=FFFFFFFC00000002, overflow=1 at done.
REQ-036 len=0 start -> busy one cycle (DONE), done=1, result=0, in_ready never asserted.
REQ-037 len=4, abort after 2 accepts -> IDLE next cycle, result=0, no done; then len=1 (3,3) -> result=9.
REQ-038 rst_n low mid-RUN between edges -> outputs zero immediately; start during DONE cycle ignored, no second job.
